// File: rtl/run_scan_arbiter.sv
// Round-robin arbiter that time-shares one serial run-of-ones detector.
// The granted word is scanned MSB-first, and a hit count and match flag are returned.
module run_scan_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = 8,
    parameter int RUN_LEN = 3,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic                      det_out,
    output logic [CNT_W-1:0]          hit_count
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  hit_q, hit_d;

    logic [ID_W:0]     cand;
    logic [ID_W-1:0]   pick;
    logic              found;
    logic [ID_W:0]     win_inc;
    logic [ID_W-1:0]   rr_nx;
    logic [WORD_W-1:0] word_sel;
    logic              bit_in;
    logic [RUN_W-1:0]  run_nx;

    assign word_sel = data[int'(win_q)*WORD_W +: WORD_W];
    assign bit_in   = shift_q[WORD_W-1];

    // Pick the first requester at or above the round-robin pointer, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                pick  = cand[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer advances to the requester just after the winner.
    always_comb begin
        win_inc = {1'b0, win_q} + (ID_W+1)'(1);
        rr_nx   = win_inc[ID_W-1:0];
        if (win_inc >= (ID_W+1)'(N_REQ)) begin
            rr_nx = '0;
        end
    end

    // Saturating run length after consuming the current MSB.
    always_comb begin
        run_nx = '0;
        if (bit_in) begin
            if (run_q == RUN_W'(RUN_LEN)) begin
                run_nx = run_q;
            end else begin
                run_nx = run_q + RUN_W'(1);
            end
        end
    end

    // Next-state and datapath updates for the scan sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        id_d    = id_q;
        shift_d = shift_q;
        run_d   = run_q;
        bit_d   = bit_q;
        hit_d   = hit_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                shift_d = word_sel;
                run_d   = '0;
                bit_d   = '0;
                hit_d   = '0;
                id_d    = '0;
                rr_d    = rr_nx;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                shift_d = shift_q << 1;
                run_d   = run_nx;
                bit_d   = bit_q + CNT_W'(1);
                if (run_nx == RUN_W'(RUN_LEN)) begin
                    hit_d = hit_q + CNT_W'(1);
                end
                if (bit_q == CNT_W'(WORD_W - 1)) begin
                    id_d    = win_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            id_q    <= '0;
            shift_q <= '0;
            run_q   <= '0;
            bit_q   <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            id_q    <= id_d;
            shift_q <= shift_d;
            run_q   <= run_d;
            bit_q   <= bit_d;
            hit_q   <= hit_d;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        gnt = '0;
        if (state_q == S_GRANT) begin
            gnt[win_q] = 1'b1;
        end
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign done_id   = id_q;
    assign hit_count = hit_q;
    assign det_out   = |hit_q;

endmodule
